// File: rtl/regfile_write_arbiter_pkg.sv
// Shared CPU constants and the state encoding of the register-file write-port arbiter.
package regfile_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        WBARB_NORMAL = 1'b0,
        WBARB_FORCE  = 1'b1
    } wbarb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_sync_fifo.sv
// Small synchronous FIFO with occupancy count; the head entry is always visible on pop_data.
module regfile_write_arbiter_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic [$clog2(DEPTH + 1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Full/empty from the registered count; a full FIFO refuses a push even while popping.
    always_comb begin
        full_s    = (count_r == CNT_FULL);
        empty_s   = (count_r == {CNT_W{1'b0}});
        push_ok_s = push && !full_s;
        pop_ok_s  = pop && !empty_s;
    end

    // Storage and pointers; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Occupancy counter; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign count    = count_r;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between write-back (priority) and a buffered
// long-latency result source, forcing one buffered write after a run of denied cycles.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W       = REG_DATA_W,
    parameter int ADDR_W       = REG_ADDR_W,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                wb_we,
    input  logic [ADDR_W-1:0]                   wb_wa,
    input  logic [DATA_W-1:0]                   wb_wd,
    output logic                                wb_stall,
    input  logic                                lu_valid,
    input  logic [ADDR_W-1:0]                   lu_wa,
    input  logic [DATA_W-1:0]                   lu_wd,
    output logic                                lu_ready,
    output logic [$clog2(FIFO_DEPTH + 1)-1:0]   lu_count,
    output logic                                rf_we,
    output logic [ADDR_W-1:0]                   rf_wa,
    output logic [DATA_W-1:0]                   rf_wd
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int SC_W    = $clog2(STARVE_LIMIT + 1);
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam logic [SC_W-1:0]  SC_LIMIT = SC_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    wbarb_state_t        state_r;
    wbarb_state_t        state_next_s;
    logic [SC_W-1:0]     sc_r;
    logic [SC_W-1:0]     sc_next_s;
    logic [SC_W-1:0]     sc_inc_s;
    logic                fifo_empty_s;
    logic                push_s;
    logic                grant_wb_s;
    logic                grant_lu_s;
    logic                grant_any_s;
    logic [ENTRY_W-1:0]  push_entry_s;
    logic [ENTRY_W-1:0]  head_s;
    logic [ADDR_W-1:0]   head_wa_s;
    logic [DATA_W-1:0]   head_wd_s;
    logic [ADDR_W-1:0]   grant_wa_s;
    logic [DATA_W-1:0]   grant_wd_s;

    regfile_write_arbiter_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_lu_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (grant_lu_s),
        .pop_data  (head_s),
        .count     (lu_count)
    );

    // Long-latency handshake; ready is held low while reset is asserted.
    always_comb begin
        fifo_empty_s = (lu_count == {CNT_W{1'b0}});
        lu_ready     = reset_n && (lu_count != CNT_FULL);
        push_s       = lu_valid && lu_ready;
        push_entry_s = {lu_wa, lu_wd};
        head_wa_s    = head_s[ENTRY_W-1:DATA_W];
        head_wd_s    = head_s[DATA_W-1:0];
    end

    // Scheduler: grant selection, starvation count and next state.
    always_comb begin
        grant_wb_s   = 1'b0;
        grant_lu_s   = 1'b0;
        wb_stall     = 1'b0;
        sc_next_s    = {SC_W{1'b0}};
        state_next_s = WBARB_NORMAL;
        sc_inc_s     = (sc_r == SC_LIMIT) ? sc_r : (sc_r + SC_W'(1));
        case (state_r)
            WBARB_NORMAL: begin
                if (wb_we) begin
                    grant_wb_s = 1'b1;
                end else if (!fifo_empty_s) begin
                    grant_lu_s = 1'b1;
                end else begin
                    grant_wb_s = 1'b0;
                end
                // A waiting head that lost this cycle counts towards a forced grant.
                if (!fifo_empty_s && !grant_lu_s) begin
                    sc_next_s    = sc_inc_s;
                    state_next_s = (sc_inc_s == SC_LIMIT) ? WBARB_FORCE : WBARB_NORMAL;
                end else begin
                    sc_next_s    = {SC_W{1'b0}};
                    state_next_s = WBARB_NORMAL;
                end
            end
            WBARB_FORCE: begin
                grant_lu_s   = !fifo_empty_s;
                wb_stall     = reset_n && wb_we;
                sc_next_s    = {SC_W{1'b0}};
                state_next_s = WBARB_NORMAL;
            end
            default: begin
                sc_next_s    = {SC_W{1'b0}};
                state_next_s = WBARB_NORMAL;
            end
        endcase
    end

    // Mux of the granted request onto the write port.
    always_comb begin
        grant_any_s = 1'b0;
        grant_wa_s  = head_wa_s;
        grant_wd_s  = head_wd_s;
        if (grant_wb_s) begin
            grant_any_s = 1'b1;
            grant_wa_s  = wb_wa;
            grant_wd_s  = wb_wd;
        end else if (grant_lu_s) begin
            grant_any_s = 1'b1;
        end else begin
            grant_any_s = 1'b0;
        end
    end

    // Scheduler state and starvation counter; reset abandons a pending forced grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= WBARB_NORMAL;
            sc_r    <= {SC_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            sc_r    <= sc_next_s;
        end
    end

    // Registered write port; register 0 writes are consumed but never enabled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rf_we <= 1'b0;
            rf_wa <= {ADDR_W{1'b0}};
            rf_wd <= {DATA_W{1'b0}};
        end else if (grant_any_s) begin
            rf_we <= (grant_wa_s != ADDR_W'(REG_ZERO));
            rf_wa <= grant_wa_s;
            rf_wd <= grant_wd_s;
        end else begin
            rf_we <= 1'b0;
            rf_wa <= rf_wa;
            rf_wd <= rf_wd;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts every register-file write,
// a separate monitor compares the write port at each clock edge.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct {
        int          tag;
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    logic        clk = 1'b1;
    logic        reset_n = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_wa = 5'd0;
    logic [31:0] wb_wd = 32'd0;
    logic        wb_stall;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_wa = 5'd0;
    logic [31:0] lu_wd = 32'd0;
    logic        lu_ready;
    logic [1:0]  lu_count;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  pcnt = 0;
    wr_t exp_q[$];
    wr_t m_fifo[$];
    int  m_wait = 0;
    bit  m_force = 1'b0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wb_we    (wb_we),
        .wb_wa    (wb_wa),
        .wb_wd    (wb_wd),
        .wb_stall (wb_stall),
        .lu_valid (lu_valid),
        .lu_wa    (lu_wa),
        .lu_wd    (lu_wd),
        .lu_ready (lu_ready),
        .lu_count (lu_count),
        .rf_we    (rf_we),
        .rf_wa    (rf_wa),
        .rf_wd    (rf_wd)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: one call per cycle, with inputs applied and before the rising edge.
    task automatic model_step();
        int  sz;
        bit  g_wb;
        bit  g_lu;
        bit  denied;
        bit  e_ready;
        wr_t w;
        if (!reset_n) begin
            chk("reset_lu_ready", lu_ready, 1'b0);
            chk("reset_wb_stall", wb_stall, 1'b0);
            m_fifo.delete();
            m_wait  = 0;
            m_force = 1'b0;
        end else begin
            sz      = m_fifo.size();
            e_ready = (sz < DEPTH);
            chk("lu_ready", lu_ready, e_ready);
            chk("wb_stall", wb_stall, m_force && wb_we);
            chk("lu_count", lu_count, sz);
            g_wb = !m_force && wb_we;
            g_lu = !g_wb && (sz > 0);
            if (g_wb && wb_wa != 5'd0) begin
                w.tag = cyc; w.wa = wb_wa; w.wd = wb_wd;
                exp_q.push_back(w);
            end
            if (g_lu && m_fifo[0].wa != 5'd0) begin
                w = m_fifo[0];
                w.tag = cyc;
                exp_q.push_back(w);
            end
            denied  = !m_force && (sz > 0) && !g_lu;
            m_wait  = denied ? m_wait + 1 : 0;
            m_force = (m_wait >= LIMIT);
            if (m_force) m_wait = 0;
            if (g_lu) void'(m_fifo.pop_front());
            if (lu_valid && e_ready) begin
                w.tag = 0; w.wa = lu_wa; w.wd = lu_wd;
                m_fifo.push_back(w);
            end
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic lv, input logic [4:0] lwa, input logic [31:0] lwd);
        @(negedge clk);
        cyc++;
        reset_n  = rst;
        wb_we    = we;
        wb_wa    = wa;
        wb_wd    = wd;
        lu_valid = lv;
        lu_wa    = lwa;
        lu_wd    = lwd;
        #1;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Monitor: the write predicted in cycle N must appear right after edge N.
    initial begin
        wr_t e;
        bit  exp_we;
        forever begin
            @(posedge clk);
            pcnt++;
            #1;
            exp_we = (exp_q.size() > 0) && (exp_q[0].tag == pcnt);
            chk("rf_we", rf_we, exp_we);
            if (exp_we) begin
                e = exp_q.pop_front();
                if (rf_we) begin
                    chk("rf_wa", rf_wa, e.wa);
                    chk("rf_wd", rf_wd, e.wd);
                end
            end
        end
    end

    initial begin
        logic [31:0] da;
        logic [31:0] lu_vals [3];
        int          lu_idx;
        int          stall_step;
        int          n_stall;
        logic        rst, we, lv, hold_wb, hold_lu;
        logic [4:0]  wa, lwa;
        logic [31:0] wd, lwd;

        // Reset held for three cycles with both requesters active.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_wa", rf_wa, 5'd0);
        chk("rst_rf_wd", rf_wd, 32'd0);
        chk("rst_release_ready", lu_ready, 1'b1);
        chk("rst_release_count", lu_count, 2'd0);

        // Write-back only, then a write to register 0.
        drive(1'b1, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0);
        chk("wb_only_stall", wb_stall, 1'b0);
        idle(1);
        chk("wb_only_we", rf_we, 1'b1);
        chk("wb_only_wa", rf_wa, 5'd5);
        chk("wb_only_wd", rf_wd, 32'hA5A5A5A5);
        drive(1'b1, 1'b1, 5'd0, 32'h11112222, 1'b0, 5'd0, 32'd0);
        idle(1);
        chk("wb_r0_we", rf_we, 1'b0);
        chk("wb_r0_wd", rf_wd, 32'h11112222);

        // Long-latency only: written two edges after the push.
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h5A5A5A5A);
        idle(1);
        chk("lu_only_early", rf_we, 1'b0);
        idle(1);
        chk("lu_only_we", rf_we, 1'b1);
        chk("lu_only_wa", rf_wa, 5'd10);
        chk("lu_only_wd", rf_wd, 32'h5A5A5A5A);
        chk("lu_only_count", lu_count, 2'd0);

        // Starvation: one buffered entry against continuous write-back.
        da = 32'd1; stall_step = -1; n_stall = 0;
        for (int s = 1; s <= 10; s++) begin
            drive(1'b1, 1'b1, da[4:0], da, (s == 1), 5'd15, 32'h1);
            if (wb_stall) begin
                n_stall++;
                stall_step = s;
            end else begin
                da++;
            end
        end
        chk("starve_stall_step", stall_step, 6);
        chk("starve_stall_count", n_stall, 1);
        idle(3);

        // Full FIFO: three back-to-back offers under continuous write-back.
        lu_vals[0] = 32'hDEADBEEF; lu_vals[1] = 32'hCAFEF00D; lu_vals[2] = 32'h12345678;
        lu_idx = 0; da = 32'd1;
        for (int s = 1; s <= 16; s++) begin
            lv = (lu_idx < 3);
            drive(1'b1, 1'b1, da[4:0], da, lv, 5'(20 + lu_idx), lu_vals[(lu_idx < 3) ? lu_idx : 0]);
            if (s == 3) chk("full_lu_ready", lu_ready, 1'b0);
            if (lv && lu_ready) lu_idx++;
            if (!wb_stall) da++;
        end
        chk("full_all_accepted", lu_idx, 3);
        idle(6);

        // Reset pulse while two entries are buffered and a forced grant is due.
        da = 32'd1;
        for (int s = 1; s <= 5; s++) begin
            drive(1'b1, 1'b1, da[4:0], da, (s <= 2), 5'(24 + s), 32'hBAD0_0000 + s);
            da++;
        end
        chk("midrst_count_before", lu_count, 2'd2);
        drive(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
        drive(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
        chk("midrst_count", lu_count, 2'd0);
        chk("midrst_stall", wb_stall, 1'b0);
        chk("midrst_rf_wa", rf_wa, 5'd0);
        chk("midrst_rf_wd", rf_wd, 32'd0);
        idle(3);

        // Randomised traffic honouring stall and ready handshakes.
        hold_wb = 1'b0; hold_lu = 1'b0;
        we = 1'b0; wa = 5'd0; wd = 32'd0; lv = 1'b0; lwa = 5'd0; lwd = 32'd0;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) != 0);
            if (!hold_wb) begin
                we = ($urandom_range(0, 9) < 6);
                wa = 5'($urandom_range(0, 31));
                wd = $urandom;
            end
            if (!hold_lu) begin
                lv  = 1'($urandom_range(0, 1));
                lwa = 5'($urandom_range(0, 31));
                lwd = $urandom;
            end
            drive(rst, we, wa, wd, lv, lwa, lwd);
            hold_wb = wb_stall;
            hold_lu = lv && !lu_ready && reset_n;
        end

        idle(8);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

- Shares the single register-file write port between two writers:
  - the write-back stage, which has priority;
  - a long-latency result source (multi-cycle unit or late memory return), which is buffered.
- Contains a 2-entry holding FIFO for the long-latency source, a starvation counter and a two-state scheduler.
- Drives the registered write port (`rf_we`/`rf_wa`/`rf_wd`) and stalls write-back when the buffered source must be served.
- Sits between the write-back stage outputs and the register file.

## Interface
- `DATA_W`, 32, write-data width.
- `ADDR_W`, 5, register-address width.
- `FIFO_DEPTH`, 2, entries buffered from the long-latency source (power of two, ≥2).
- `STARVE_LIMIT`, 4, consecutive denied cycles before a forced grant (≥1).

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `wb_we`  in  1  write-back write request (the stage's writeEnable).
- `wb_wa`  in  ADDR_W  write-back destination register.
- `wb_wd`  in  DATA_W  write-back data.
- `wb_stall`  out  1  write-back must hold `wb_*` stable this cycle; its write was not taken.
- `lu_valid`  in  1  long-latency result offered.
- `lu_wa`  in  ADDR_W  long-latency destination register.
- `lu_wd`  in  DATA_W  long-latency data.
- `lu_ready`  out  1  FIFO can accept; a transfer occurs when `lu_valid && lu_ready`.
- `lu_count`  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- `rf_we`  out  1  register-file write enable (registered).
- `rf_wa`  out  ADDR_W  register-file write address (registered).
- `rf_wd`  out  DATA_W  register-file write data (registered).

## Operation
- FIFO
  - Push on `lu_valid && lu_ready`; pop when the head is granted.
  - `lu_ready = (lu_count != FIFO_DEPTH)`, computed from registered count only. It does not depend on a same-cycle pop, so a full FIFO rejects a push even while popping.
  - Simultaneous push and pop on a non-full FIFO leaves `lu_count` unchanged.
- State machine with two states, NORMAL and FORCE.
  - NORMAL:
    - If `wb_we`, grant WB.
    - Else if FIFO non-empty, grant FIFO head.
    - Else no grant.
  - Starvation counter (`sc`): in NORMAL, `sc` increments when the FIFO is non-empty and not granted, saturating at `STARVE_LIMIT`. It clears whenever the FIFO is granted or is empty.
  - NORMAL→FORCE when `sc` reaches `STARVE_LIMIT` (next-state computed from the incremented value).
  - FORCE:
    - Grant FIFO head unconditionally.
    - Assert `wb_stall = wb_we`.
    - Next state NORMAL; `sc` clears.
  - In NORMAL, `wb_stall = 0`, so WB is never stalled twice in a row.
- Register 0 is hardwired zero.
  - A granted write with address 0 is consumed normally (pop, or WB not stalled) but produces `rf_we = 0`.
  - `rf_wa`/`rf_wd` still update.
- Same-address collision between WB and the FIFO head: no merging; the grant order defines the final value (the later grant wins in the register file).
- Reset (`reset_n = 0` at an edge):
  - FIFO emptied, buffered entries discarded.
  - `lu_count = 0`, `sc = 0`, state NORMAL.
  - `rf_we = 0`, `rf_wa = 0`, `rf_wd = 0`.
  - During reset cycles `lu_ready = 0` and `wb_stall = 0`; an in-flight forced grant is abandoned.
  - First cycle after release: `lu_ready = 1`.

## Timing
- Grant-to-write latency is 1 cycle: the granted entry appears on `rf_*` at the next rising edge.
- Push-to-write minimum latency is 2 cycles: push at edge N, grant in cycle N, `rf_we` after edge N+1.
- `wb_stall` is combinational from state and `wb_we`, and is valid in the same cycle.
  - The pipeline must hold `wb_*` for exactly one extra cycle.
  - The held request is granted in the following NORMAL cycle.
- Worst-case FIFO head wait under continuous `wb_we` is `STARVE_LIMIT + 1` cycles from reaching head to grant.
- Throughput is one register-file write per cycle.

## Structure
- Shared CPU package holds `REG_ADDR_W` = 5, `REG_DATA_W` = 32, `REG_ZERO` = 5'd0, and the state enum `wbarb_state_t {WBARB_NORMAL, WBARB_FORCE}`.
- One natural sub-module is `sync_fifo`:
  - parameterised width/depth;
  - count output;
  - synchronous active-low reset.
- Scheduler, counter and output registers live in the top module.

## Test plan
- Reset: hold `reset_n = 0` 3 cycles with `wb_we = 1`, `lu_valid = 1` → `rf_we = 0`, `lu_ready = 0`, `wb_stall = 0`. After release `lu_ready = 1`, `lu_count = 0`.
- WB only:
  - `wb_we = 1`, `wb_wa = 5`, `wb_wd = 32'hA5A5A5A5` → next cycle `rf_we = 1`, `rf_wa = 5`, `rf_wd = 32'hA5A5A5A5`, `wb_stall = 0`.
  - `wb_wa = 0` → `rf_we = 0`.
- LU only: push `lu_wa = 10`, `lu_wd = 32'h5A5A5A5A` with `wb_we = 0` → `rf_we = 1`, `rf_wa = 10`, `rf_wd = 32'h5A5A5A5A` two edges after push; `lu_count` returns to 0.
- Starvation:
  - Stimulus: continuous `wb_we` (DA 1,2,3,...) plus one FIFO entry (`lu_wa = 15`, `lu_wd = 32'h1`).
  - Required: WB wins 4 cycles; then `wb_stall = 1` for one cycle and `rf_wa = 15` is written; the stalled WB write lands the next cycle, with no WB write lost or duplicated.
- Full FIFO: 3 back-to-back `lu_valid` under continuous `wb_we` → `lu_ready` drops after 2 pushes and third entry waits; entries are written in push order (`DEADBEEF`, then `CAFEF00D`).
- Reset mid-operation: FIFO holding 2 entries and state FORCE, pulse `reset_n = 0` one cycle → no `rf_we` for the discarded entries; `lu_count = 0`; state NORMAL.
